// File: rtl/n5_soc_core.sv
`default_nettype none
// ============================================================================
// Module   : n5_soc_core
// Summary  : Sequencer core that fetches command words from quad-SPI flash
//            (SQOR 0x6B) and executes them on a GPIO bank and debug register.
//            Optional N5_PERF_CNT_EN adds cycle/instret counters.
// Revision : 1.0
// ============================================================================
module n5_soc_core #(
    parameter logic [23:0] RESET_PC     = 24'h000000,
    parameter int          DUMMY_CYCLES = 8
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic [3:0]  fdi_Sys0_S0,
    output logic [3:0]  fdo_Sys0_S0,
    output logic        fdoe_Sys0_S0,
    output logic        fsclk_Sys0_S0,
    output logic        fcen_Sys0_S0,
    input  logic [15:0] GPIOIN_Sys0_S2,
    output logic [15:0] GPIOOUT_Sys0_S2,
    output logic [15:0] GPIOPU_Sys0_S2,
    output logic [15:0] GPIOPD_Sys0_S2,
    output logic [15:0] GPIOOEN_Sys0_S2,
    output logic [3:0]  db_reg_Sys0,
`ifdef N5_PERF_CNT_EN
    output logic [31:0] cycle_cnt,
    output logic [31:0] instret_cnt,
`endif
    output logic        halted
);

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_CMD    = 4'd1;
    localparam logic [3:0] S_ADDR   = 4'd2;
    localparam logic [3:0] S_DUMMY  = 4'd3;
    localparam logic [3:0] S_DATA   = 4'd4;
    localparam logic [3:0] S_EXEC   = 4'd5;
    localparam logic [3:0] S_WAIT   = 4'd6;
    localparam logic [3:0] S_WAITIN = 4'd7;
    localparam logic [3:0] S_HALT   = 4'd8;

    localparam logic [7:0] CMD_SQOR = 8'h6B;

    logic [3:0]  state_q,  state_d;
    logic [5:0]  cnt_q,    cnt_d;
    logic        idle_q,   idle_d;
    logic        sck_q,    sck_d;
    logic        fcen_q,   fcen_d;
    logic        fdoe_q,   fdoe_d;
    logic [3:0]  fdo_q,    fdo_d;
    logic [31:0] sr_q,     sr_d;
    logic [31:0] acc_q,    acc_d;
    logic [23:0] pc_q,     pc_d;
    logic [15:0] gout_q,   gout_d;
    logic [15:0] goen_q,   goen_d;
    logic [15:0] gpu_q,    gpu_d;
    logic [15:0] gpd_q,    gpd_d;
    logic [3:0]  db_q,     db_d;
    logic        halted_q, halted_d;
    logic [15:0] wait_q,   wait_d;
    logic [11:0] sync1_q,  sync1_d;
    logic [11:0] sync2_q,  sync2_d;

    logic [31:0] word;
    logic [3:0]  op;
    logic [11:0] mask;
    logic [15:0] imm;
    logic        start_fetch;
    logic        unused_gpioin_hi;

    assign unused_gpioin_hi = ^GPIOIN_Sys0_S2[15:12];

    // Nibbles arrive high-first per byte, bytes arrive little-endian.
    assign word = {acc_q[7:0], acc_q[15:8], acc_q[23:16], acc_q[31:24]};
    assign op   = word[31:28];
    assign mask = word[27:16];
    assign imm  = word[15:0];

`ifdef N5_PERF_CNT_EN
    logic [31:0] cyc_q, cyc_d;
    logic [31:0] ret_q, ret_d;

    always_comb begin
        cyc_d = cyc_q;
        ret_d = ret_q;
        if (!halted_q) begin
            cyc_d = cyc_q + 32'd1;
        end
        if (state_q == S_EXEC) begin
            ret_d = ret_q + 32'd1;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            cyc_q <= 32'd0;
            ret_q <= 32'd0;
        end else begin
            cyc_q <= cyc_d;
            ret_q <= ret_d;
        end
    end

    assign cycle_cnt   = cyc_q;
    assign instret_cnt = ret_q;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idle_d      = idle_q;
        sck_d       = sck_q;
        fcen_d      = fcen_q;
        fdoe_d      = fdoe_q;
        fdo_d       = fdo_q;
        sr_d        = sr_q;
        acc_d       = acc_q;
        pc_d        = pc_q;
        gout_d      = gout_q;
        goen_d      = goen_q;
        gpu_d       = gpu_q;
        gpd_d       = gpd_q;
        db_d        = db_q;
        halted_d    = halted_q;
        wait_d      = wait_q;
        sync1_d     = GPIOIN_Sys0_S2[11:0];
        sync2_d     = sync1_q;
        start_fetch = 1'b0;

        case (state_q)
            S_IDLE: begin
                idle_d      = 1'b1;
                start_fetch = idle_q;
            end
            S_CMD, S_ADDR, S_DUMMY, S_DATA: begin
                sck_d = ~sck_q;
                if (!sck_q) begin
                    // Rising SCK edge: flash data is stable here.
                    if (state_q == S_DATA) begin
                        acc_d = {acc_q[27:0], fdi_Sys0_S0};
                    end
                end else begin
                    cnt_d = cnt_q + 6'd1;
                    case (state_q)
                        S_CMD: begin
                            fdo_d[0] = sr_q[31];
                            sr_d     = {sr_q[30:0], 1'b0};
                            if (cnt_q == 6'd7) begin
                                state_d = S_ADDR;
                                cnt_d   = 6'd0;
                            end
                        end
                        S_ADDR: begin
                            if (cnt_q == 6'd23) begin
                                state_d = S_DUMMY;
                                cnt_d   = 6'd0;
                                fdoe_d  = 1'b0;
                                fdo_d   = 4'hF;
                            end else begin
                                fdo_d[0] = sr_q[31];
                                sr_d     = {sr_q[30:0], 1'b0};
                            end
                        end
                        S_DUMMY: begin
                            if (cnt_q == 6'(DUMMY_CYCLES - 1)) begin
                                state_d = S_DATA;
                                cnt_d   = 6'd0;
                            end
                        end
                        default: begin
                            if (cnt_q == 6'd7) begin
                                state_d = S_EXEC;
                                cnt_d   = 6'd0;
                                fcen_d  = 1'b1;
                            end
                        end
                    endcase
                end
            end
            S_EXEC: begin
                pc_d    = pc_q + 24'd4;
                state_d = S_IDLE;
                idle_d  = 1'b0;
                case (op)
                    4'h1: gout_d = imm;
                    4'h2: goen_d = imm;
                    4'h3: gpu_d  = imm;
                    4'h4: gpd_d  = imm;
                    4'h5: db_d   = imm[3:0];
                    4'h6: begin
                        if (imm != 16'd0) begin
                            state_d = S_WAIT;
                            wait_d  = imm;
                        end
                    end
                    4'h7: pc_d = {6'd0, imm, 2'b00};
                    4'h8: state_d = S_WAITIN;
                    4'hF: begin
                        halted_d = 1'b1;
                        state_d  = S_HALT;
                    end
                    default: ;
                endcase
            end
            S_WAIT: begin
                wait_d = wait_q - 16'd1;
                if (wait_q == 16'd1) begin
                    state_d = S_IDLE;
                end
            end
            S_WAITIN: begin
                // CE# has already been high for two cycles, so fetch directly.
                start_fetch = ((sync2_q & mask) == (imm[11:0] & mask));
            end
            S_HALT: ;
            default: state_d = S_IDLE;
        endcase

        if (start_fetch) begin
            state_d = S_CMD;
            idle_d  = 1'b0;
            cnt_d   = 6'd0;
            fcen_d  = 1'b0;
            fdoe_d  = 1'b1;
            fdo_d   = {3'b111, CMD_SQOR[7]};
            sr_d    = {CMD_SQOR[6:0], pc_q, 1'b0};
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q  <= S_IDLE;
            cnt_q    <= 6'd0;
            idle_q   <= 1'b0;
            sck_q    <= 1'b0;
            fcen_q   <= 1'b1;
            fdoe_q   <= 1'b0;
            fdo_q    <= 4'hF;
            sr_q     <= 32'd0;
            acc_q    <= 32'd0;
            pc_q     <= RESET_PC;
            gout_q   <= 16'h0000;
            goen_q   <= 16'h0000;
            gpu_q    <= 16'h0000;
            gpd_q    <= 16'h0000;
            db_q     <= 4'h0;
            halted_q <= 1'b0;
            wait_q   <= 16'd0;
            sync1_q  <= 12'd0;
            sync2_q  <= 12'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idle_q   <= idle_d;
            sck_q    <= sck_d;
            fcen_q   <= fcen_d;
            fdoe_q   <= fdoe_d;
            fdo_q    <= fdo_d;
            sr_q     <= sr_d;
            acc_q    <= acc_d;
            pc_q     <= pc_d;
            gout_q   <= gout_d;
            goen_q   <= goen_d;
            gpu_q    <= gpu_d;
            gpd_q    <= gpd_d;
            db_q     <= db_d;
            halted_q <= halted_d;
            wait_q   <= wait_d;
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
        end
    end

    assign fdo_Sys0_S0     = fdo_q;
    assign fdoe_Sys0_S0    = fdoe_q;
    assign fsclk_Sys0_S0   = sck_q;
    assign fcen_Sys0_S0    = fcen_q;
    assign GPIOOUT_Sys0_S2 = gout_q;
    assign GPIOOEN_Sys0_S2 = goen_q;
    assign GPIOPU_Sys0_S2  = gpu_q;
    assign GPIOPD_Sys0_S2  = gpd_q;
    assign db_reg_Sys0     = db_q;
    assign halted          = halted_q;

endmodule
`default_nettype wire

// File: tb/tb_n5_soc_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_n5_soc_core
// Summary  : Self-checking bench with a behavioural SQOR flash and an
//            instruction-level reference interpreter for n5_soc_core.
// Revision : 1.0
// ============================================================================
module tb_n5_soc_core;

    localparam int DUMMY = 8;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic [3:0]  fdi = 4'h0;
    logic [3:0]  fdo;
    logic        fdoe, fsclk, fcen;
    logic [15:0] gpin = 16'h0;
    logic [15:0] gout, gpu, gpd, goen;
    logic [3:0]  db;
    logic        halted;
`ifdef N5_PERF_CNT_EN
    logic [31:0] cycle_cnt, instret_cnt;
`endif

    n5_soc_core #(.RESET_PC(24'h000000), .DUMMY_CYCLES(DUMMY)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .fdi_Sys0_S0(fdi), .fdo_Sys0_S0(fdo), .fdoe_Sys0_S0(fdoe),
        .fsclk_Sys0_S0(fsclk), .fcen_Sys0_S0(fcen),
        .GPIOIN_Sys0_S2(gpin), .GPIOOUT_Sys0_S2(gout), .GPIOPU_Sys0_S2(gpu),
        .GPIOPD_Sys0_S2(gpd), .GPIOOEN_Sys0_S2(goen), .db_reg_Sys0(db),
`ifdef N5_PERF_CNT_EN
        .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt),
`endif
        .halted(halted)
    );

    always #5 HCLK = ~HCLK;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural flash: 256 bytes, SQOR with DUMMY dummy clocks.
    // ------------------------------------------------------------------
    logic [7:0]  mem [256];
    int          cyc = 0;
    int          bitn = 0;
    int          n_started = 0;
    int          fall_cyc = 0;
    int          rise_cyc = 0;
    int          sck_idle_edges = 0;
    int          sck_edges = 0;
    logic [31:0] ca = 32'd0;
    logic [23:0] obs_addr [$];
    logic [7:0]  obs_cmd  [$];
    int          gaps     [$];
    int          lowlen   [$];
    bit          seen1111 = 1'b0;

    always @(posedge HCLK) cyc++;

    always @(negedge fcen) begin
        bitn = 0;
        n_started++;
        fall_cyc = cyc;
        gaps.push_back(cyc - rise_cyc);
    end

    always @(posedge fcen) begin
        if (bitn >= 32) begin
            obs_cmd.push_back(ca[31:24]);
            obs_addr.push_back(ca[23:0]);
            lowlen.push_back(cyc - fall_cyc);
        end
        rise_cyc = cyc;
    end

    always @(posedge fsclk) begin
        sck_edges++;
        if (fcen) sck_idle_edges++;
        else begin
            if (bitn < 32) ca = {ca[30:0], fdo[0]};
            bitn++;
        end
    end

    always @(negedge fsclk) begin
        int k;
        logic [7:0] b;
        if (!fcen && bitn >= 32 + DUMMY) begin
            k = bitn - 32 - DUMMY;
            b = mem[8'(ca[7:0] + 8'(k / 2))];
            fdi = (k % 2 == 0) ? b[7:4] : b[3:0];
        end
    end

    always @(negedge HCLK) if (gout == 16'h1111) seen1111 = 1'b1;

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = (i % 4 == 3) ? 8'hF0 : 8'h00;
    endtask

    task automatic put_word(input int addr, input logic [31:0] w);
        mem[addr]     = w[7:0];
        mem[addr + 1] = w[15:8];
        mem[addr + 2] = w[23:16];
        mem[addr + 3] = w[31:24];
    endtask

    task automatic clear_obs();
        obs_addr.delete(); obs_cmd.delete(); gaps.delete(); lowlen.delete();
        n_started = 0;
        seen1111  = 1'b0;
        rise_cyc  = cyc;
    endtask

    task automatic do_reset();
        HRESETn = 1'b0;
        repeat (3) @(posedge HCLK);
        clear_obs();
        @(negedge HCLK);
        HRESETn = 1'b1;
    endtask

    task automatic run_until_halt(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge HCLK);
            if (halted === 1'b1) begin ok = 1'b1; break; end
        end
    endtask

    function automatic logic [31:0] qa(input int idx);
        return (idx < obs_addr.size()) ? 32'(obs_addr[idx]) : 32'hDEAD_BEEF;
    endfunction

    // ------------------------------------------------------------------
    // Reference interpreter: walks the program in flash word by word.
    // ------------------------------------------------------------------
    logic [15:0] e_out, e_oen, e_pu, e_pd;
    logic [3:0]  e_db;
    logic [23:0] exp_addrs [$];

    task automatic model_run();
        logic [23:0] pc;
        logic [31:0] w;
        e_out = 0; e_oen = 0; e_pu = 0; e_pd = 0; e_db = 0;
        exp_addrs.delete();
        pc = 24'h0;
        for (int n = 0; n < 64; n++) begin
            w = {mem[pc[7:0] + 8'd3], mem[pc[7:0] + 8'd2], mem[pc[7:0] + 8'd1], mem[pc[7:0]]};
            exp_addrs.push_back(pc);
            pc = pc + 24'd4;
            case (w[31:28])
                4'h1: e_out = w[15:0];
                4'h2: e_oen = w[15:0];
                4'h3: e_pu  = w[15:0];
                4'h4: e_pd  = w[15:0];
                4'h5: e_db  = w[3:0];
                4'h7: pc = 24'(w[15:0]) * 24'd4;
                default: ;
            endcase
            if (w[31:28] == 4'hF) break;
        end
    endtask

    typedef struct {
        logic [31:0] word;
        logic [15:0] out, oen, pu, pd;
        logic [3:0]  dbv;
    } vec_t;

    initial begin
        vec_t vecs [9];
        logic [3:0] oplist [11];
        bit ok;
        int k, mism, e0, t0;
        logic [31:0] w;

        vecs[0] = '{32'h1000BEEF, 16'hBEEF, 16'h0000, 16'h0000, 16'h0000, 4'h0};
        vecs[1] = '{32'h2000F00F, 16'h0000, 16'hF00F, 16'h0000, 16'h0000, 4'h0};
        vecs[2] = '{32'h30001234, 16'h0000, 16'h0000, 16'h1234, 16'h0000, 4'h0};
        vecs[3] = '{32'h4000ABCD, 16'h0000, 16'h0000, 16'h0000, 16'hABCD, 4'h0};
        vecs[4] = '{32'h5FFF0FF7, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 4'h7};
        vecs[5] = '{32'h0000FFFF, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 4'h0};
        vecs[6] = '{32'hA0001234, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 4'h0};
        vecs[7] = '{32'h6000000A, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 4'h0};
        vecs[8] = '{32'h80000055, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 4'h0};
        oplist  = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hC};

        // Reset values and first-fetch serialisation.
        clear_mem();
        put_word(0, 32'h100000A5);
        repeat (4) @(negedge HCLK);
        chk("rst_fcen", fcen, 1);   chk("rst_fsclk", fsclk, 0);
        chk("rst_fdoe", fdoe, 0);   chk("rst_fdo", fdo, 4'hF);
        chk("rst_gout", gout, 0);   chk("rst_goen", goen, 0);
        chk("rst_gpu", gpu, 0);     chk("rst_gpd", gpd, 0);
        chk("rst_db", db, 0);       chk("rst_halted", halted, 0);
        do_reset();
        run_until_halt(2000, ok);
        chk("t1_halt", ok, 1);
        chk("t1_gout", gout, 16'h00A5);
        chk("t1_cmd", (obs_cmd.size() > 0) ? 32'(obs_cmd[0]) : 32'hFFFF, 32'h6B);
        chk("t1_addr0", qa(0), 0);
        chk("t1_lowlen", (lowlen.size() > 0) ? 32'(lowlen[0]) : 32'hFFFF, 96);

        // Table of single-word programs followed by EBREAK.
        for (int v = 0; v < 9; v++) begin
            clear_mem();
            put_word(0, vecs[v].word);
            do_reset();
            run_until_halt(2000, ok);
            chk("vec_halt", ok, 1);
            chk("vec_gout", gout, vecs[v].out);
            chk("vec_goen", goen, vecs[v].oen);
            chk("vec_gpu", gpu, vecs[v].pu);
            chk("vec_gpd", gpd, vecs[v].pd);
            chk("vec_db", db, vecs[v].dbv);
            chk("vec_ntxn", obs_addr.size(), 2);
            chk("vec_addr1", qa(1), 4);
        end

        // db_reg then EBREAK; no activity afterwards.
        clear_mem();
        put_word(0, 32'h5000000C);
        put_word(4, 32'hF0000000);
        do_reset();
        run_until_halt(2000, ok);
        chk("t2_halt", ok, 1);
        chk("t2_db", db, 4'hC);
        e0 = sck_edges; t0 = n_started;
        repeat (400) @(negedge HCLK);
        chk("t2_fcen_hold", fcen, 1);
        chk("t2_no_sck", sck_edges - e0, 0);
        chk("t2_no_fetch", n_started - t0, 0);
        chk("t2_still_halted", halted, 1);

        // JUMP skips the word at 0x4.
        clear_mem();
        put_word(0, 32'h70000004);
        put_word(4, 32'h10001111);
        put_word(16, 32'h10002222);
        put_word(20, 32'hF0000000);
        do_reset();
        run_until_halt(3000, ok);
        chk("t3_halt", ok, 1);
        chk("t3_gout", gout, 16'h2222);
        chk("t3_never1111", seen1111, 0);
        chk("t3_ntxn", obs_addr.size(), 3);
        chk("t3_addr1", qa(1), 24'h000010);
        chk("t3_addr2", qa(2), 24'h000014);

        // WAIT 100 stretches the gap between fetches.
        clear_mem();
        put_word(0, 32'h60000064);
        put_word(4, 32'h100000FF);
        do_reset();
        run_until_halt(3000, ok);
        chk("t4_halt", ok, 1);
        chk("t4_gout", gout, 16'h00FF);
        chk("t4_gap", (gaps.size() > 1) ? 32'(gaps[1] >= 100) : 32'd0, 1);

        // WAIT_IN blocks until masked GPIOIN matches.
        clear_mem();
        put_word(0, 32'h80030002);
        put_word(4, 32'h10000077);
        gpin = 16'h0000;
        do_reset();
        repeat (300) @(negedge HCLK);
        chk("t5_stall0", n_started, 1);
        gpin = 16'h0001;
        repeat (30) @(negedge HCLK);
        chk("t5_stall1", n_started, 1);
        chk("t5_fcen", fcen, 1);
        gpin = 16'h0002;
        k = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge HCLK); #1;
            k++;
            if (!fcen) break;
        end
        chk("t5_latency_le4", 32'(k <= 4), 1);
        run_until_halt(2000, ok);
        chk("t5_halt", ok, 1);
        chk("t5_gout", gout, 16'h0077);
        gpin = 16'h0000;

        // Reset during DATA of the second fetch.
        clear_mem();
        put_word(0, 32'h100000A5);
        put_word(4, 32'h10005555);
        do_reset();
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge HCLK);
            if (n_started == 2 && bitn >= 32 + DUMMY + 3 && !fcen) begin ok = 1'b1; break; end
        end
        chk("t6_reached_data", ok, 1);
        chk("t6_gout_before", gout, 16'h00A5);
        HRESETn = 1'b0;
        #1;
        chk("t6_fcen", fcen, 1);   chk("t6_fdoe", fdoe, 0);
        chk("t6_fsclk", fsclk, 0); chk("t6_gout", gout, 0);
        chk("t6_goen", goen, 0);   chk("t6_gpu", gpu, 0);
        chk("t6_gpd", gpd, 0);
        repeat (2) @(posedge HCLK);
        clear_obs();
        @(negedge HCLK);
        HRESETn = 1'b1;
        run_until_halt(3000, ok);
        chk("t6_halt", ok, 1);
        chk("t6_restart_addr", qa(0), 0);
        chk("t6_gout_after", gout, 16'h5555);

        // Random programs against the reference interpreter.
        for (int p = 0; p < 15; p++) begin
            clear_mem();
            for (int i = 0; i < 9; i++) begin
                logic [3:0] op;
                logic [15:0] imm;
                op  = oplist[$urandom_range(0, 10)];
                imm = 16'($urandom);
                if (op == 4'h6) imm = 16'($urandom_range(0, 20));
                if (op == 4'h7) imm = 16'($urandom_range(i + 1, 9));
                w = {op, 12'($urandom), imm};
                if (op == 4'h8) w[27:16] = 12'h000;
                put_word(i * 4, w);
            end
            put_word(36, 32'hF0000000);
            model_run();
            do_reset();
            run_until_halt(6000, ok);
            chk("rand_halt", ok, 1);
            chk("rand_gout", gout, e_out);
            chk("rand_goen", goen, e_oen);
            chk("rand_gpu", gpu, e_pu);
            chk("rand_gpd", gpd, e_pd);
            chk("rand_db", db, e_db);
            chk("rand_ntxn", obs_addr.size(), exp_addrs.size());
            mism = 0;
            for (int i = 0; i < exp_addrs.size(); i++)
                if (qa(i) !== 32'(exp_addrs[i])) mism++;
            chk("rand_addrs", mism, 0);
        end

        chk("sck_idle_edges", sck_idle_edges, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
